dct_zigzag_quant: RTL and testbench

//   Downstream stage of the 2-D DCT core. Accepts one 8-coefficient row per beat (8 beats = one 8x8 block).

---
 rtl/dct_pkg.sv | 42 ++++
 rtl/dct_quant_unit.sv | 43 ++++
 rtl/dct_zigzag_quant.sv | 142 ++++++++++++++
 tb/tb_dct_zigzag_quant.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants for the DCT back end: zigzag scan order,
// per-position quantiser shift and coefficient width.
package dct_pkg;

    localparam int DCT_CW = 12;

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } drain_st_t;

    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Shift grows with (r+c)/2, so high frequencies are quantised harder.
    localparam logic [2:0] QSHIFT [64] = '{
        3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
        3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4,
        3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4,
        3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5,
        3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5,
        3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6,
        3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6,
        3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7
    };

    function automatic logic [5:0] raster_rc(
        input logic [2:0] r,
        input logic [2:0] c
    );
        return {r, c};
    endfunction

endpackage

// File: rtl/dct_quant_unit.sv
// Combinational abs / shift / optional round / saturate of one coefficient.
// Define DCTQ_ROUND_EN for round-half-away-from-zero instead of truncation.
module dct_quant_unit #(
    parameter int CW = 12,
    parameter int QW = 12
) (
    input  logic [CW-1:0] x,
    input  logic [2:0]    s,
    output logic [QW-1:0] q
);

    localparam logic [CW:0] POS_MAX = (CW+1)'((1 << (QW-1)) - 1);
    localparam logic [CW:0] NEG_MAX = (CW+1)'(1 << (QW-1));

    logic          neg;
    logic [CW:0]   xe;
    logic [CW:0]   mag;
    logic [CW:0]   rnd;
    logic [CW:0]   mq;

    // One extra bit so that the most negative input has a magnitude.
    assign neg = x[CW-1];
    assign xe  = {x[CW-1], x};
    assign mag = neg ? -xe : xe;

`ifdef DCTQ_ROUND_EN
    assign rnd = (s == 3'd0) ? '0 : (CW+1)'(1) << (s - 3'd1);
`else
    assign rnd = '0;
`endif

    assign mq = (mag + rnd) >> s;

    always_comb begin
        q = '0;
        if (neg) begin
            q = (mq > NEG_MAX) ? QW'(NEG_MAX) : QW'(-mq);
        end else begin
            q = (mq > POS_MAX) ? QW'(POS_MAX) : QW'(mq);
        end
    end

endmodule

// File: rtl/dct_zigzag_quant.sv
// Ping-pong 8x8 block buffer with zigzag read-out and shift quantiser.
// Rounding mode follows DCTQ_ROUND_EN (see dct_quant_unit).
module dct_zigzag_quant
    import dct_pkg::*;
#(
    parameter int CW = DCT_CW,
    parameter int QW = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*CW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [QW-1:0]   out_data,
    output logic [5:0]      out_pos,
    output logic            out_last
);

    logic [CW-1:0] mem [2][64];

    logic [2:0]    row_q;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    full_q;
    logic [1:0]    full_d;
    drain_st_t     st_q;
    drain_st_t     st_d;

    logic          wr_acc;
    logic          row_last;
    logic          out_acc;
    logic          blk_done;

    logic          issue;
    logic          rd_bank;
    logic [5:0]    rd_pos;
    logic [5:0]    raster;
    logic [QW-1:0] q;

    assign in_ready = reset && !full_q[wr_ptr];
    assign wr_acc   = in_valid && in_ready;
    assign row_last = wr_acc && (row_q == 3'd7);
    assign out_acc  = out_valid && out_ready;
    assign blk_done = out_acc && out_last;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int c = 0; c < 8; c++) begin
                mem[wr_ptr][raster_rc(row_q, 3'(c))] <=
                    in_data[CW*c +: CW];
            end
        end
    end

    always_comb begin
        full_d = full_q;
        if (blk_done) full_d[rd_ptr] = 1'b0;
        if (row_last) full_d[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_IDLE:  if (full_q[rd_ptr]) st_d = ST_DRAIN;
            ST_DRAIN: if (blk_done && !full_q[~rd_ptr]) st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
        endcase
    end

    // Last beat of a block hands straight over to the other bank.
    always_comb begin
        issue   = 1'b0;
        rd_bank = rd_ptr;
        rd_pos  = 6'd0;
        if (st_q == ST_DRAIN) begin
            unique case (1'b1)
                !out_valid: issue = 1'b1;
                blk_done: begin
                    rd_bank = ~rd_ptr;
                    issue   = full_q[~rd_ptr];
                end
                out_acc && !out_last: begin
                    rd_pos = out_pos + 6'd1;
                    issue  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign raster = ZIGZAG[rd_pos];

    dct_quant_unit #(
        .CW (CW),
        .QW (QW)
    ) u_quant (
        .x (mem[rd_bank][raster]),
        .s (QSHIFT[raster]),
        .q (q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q     <= 3'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            full_q    <= 2'b00;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pos   <= 6'd0;
            out_last  <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr_acc) begin
                row_q <= row_q + 3'd1;
                if (row_q == 3'd7) wr_ptr <= ~wr_ptr;
            end
            if (blk_done) rd_ptr <= ~rd_ptr;
            if (!out_valid || out_ready) begin
                out_valid <= issue;
                if (issue) begin
                    out_data <= q;
                    out_pos  <= rd_pos;
                    out_last <= (rd_pos == 6'd63);
                end else begin
                    out_last <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_zigzag_quant.sv
// Directed bench for dct_zigzag_quant with a zigzag scoreboard;
// a second instance built with QW=8 checks output saturation.
module tb_dct_zigzag_quant;

    localparam int CW = 12;

`ifdef DCTQ_ROUND_EN
    localparam int R63 = 1;
`else
    localparam int R63 = 0;
`endif

    typedef struct {
        int pos;
        int x;
        int s;
    } sb_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_ready8;
    logic [8*CW-1:0] in_data;
    logic          out_valid;
    logic          out_valid8;
    logic          out_ready;
    logic [11:0]   out_data;
    logic [7:0]    out_data8;
    logic [5:0]    out_pos;
    logic [5:0]    out_pos8;
    logic          out_last;
    logic          out_last8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int zz [64];
    int blk [64];
    int cap12 [64];
    int cap8 [64];
    int p63_cyc;
    sb_t sbq [$];

    dct_zigzag_quant #(.CW(12), .QW(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pos   (out_pos),
        .out_last  (out_last)
    );

    dct_zigzag_quant #(.CW(12), .QW(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in_data   (in_data),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_data  (out_data8),
        .out_pos   (out_pos8),
        .out_last  (out_last8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic int model_q(int x, int s, int qw);
        int m;
        int q;
        int hi;
        int lo;
        m = (x < 0) ? -x : x;
`ifdef DCTQ_ROUND_EN
        if (s > 0) m = m + (1 << (s - 1));
`endif
        m = m >> s;
        q = (x < 0) ? -m : m;
        hi = (1 << (qw - 1)) - 1;
        lo = -(1 << (qw - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 64; i++)
            blk[i] = int'($urandom_range(4095)) - 2048;
    endtask

    task automatic send_row(input int r, output int rdy_cyc);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        rdy_cyc = -1;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++)
            in_data[CW*c +: CW] = blk[r*8+c][CW-1:0];
        while (!acc && n < 400) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) rdy_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        chk("row_accept", 32'(acc), 1);
    endtask

    task automatic send_block(output int rdy0);
        int rc;
        sb_t e;
        rdy0 = -1;
        for (int r = 0; r < 8; r++) begin
            send_row(r, rc);
            if (r == 0) rdy0 = rc;
        end
        for (int p = 0; p < 64; p++) begin
            e.pos = p;
            e.x = blk[zz[p]];
            e.s = ((zz[p] >> 3) + (zz[p] & 7)) >> 1;
            sbq.push_back(e);
        end
    endtask

    task automatic lat_check();
        @(negedge clk);
        chk("lat_e1", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_e2", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_e3", 32'(out_valid), 1);
    endtask

    task automatic drain(input int nb, input bit tog,
                         output int f_cyc, output int l_cyc);
        int got;
        int n;
        bit stall;
        logic [11:0] pd;
        logic [5:0] pp;
        logic pl;
        sb_t e;
        got = 0;
        n = 0;
        stall = 1'b0;
        pd = '0;
        pp = '0;
        pl = 1'b0;
        f_cyc = -1;
        l_cyc = -1;
        out_ready = 1'b1;
        while (got < nb && n < 3000) begin
            @(negedge clk);
            if (stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(pd));
                chk("stall_pos", 32'(out_pos), 32'(pp));
                chk("stall_last", 32'(out_last), 32'(pl));
            end
            chk("valid8", 32'(out_valid8), 32'(out_valid));
            if (out_valid && out_ready) begin
                chk("sb_avail", 32'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("pos", 32'(out_pos), e.pos);
                    chk("data", $signed(out_data),
                        model_q(e.x, e.s, 12));
                    chk("data8", $signed(out_data8),
                        model_q(e.x, e.s, 8));
                    chk("last", 32'(out_last), 32'(e.pos == 63));
                    cap12[e.pos] = int'($signed(out_data));
                    cap8[e.pos] = int'($signed(out_data8));
                    if (e.pos == 63 && p63_cyc < 0) p63_cyc = cyc;
                end
                got++;
                if (f_cyc < 0) f_cyc = cyc;
                l_cyc = cyc;
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            pp = out_pos;
            pl = out_last;
            @(posedge clk);
            #1;
            n++;
            if (tog) out_ready = !out_ready;
        end
        out_ready = 1'b1;
        chk("beats", got, nb);
    endtask

    initial begin
        int d;
        int d2;
        int f;
        int l;
        int p;

        p = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[p] = r * 8 + (s - r);
                    p++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
                    zz[p] = r * 8 + (s - r);
                    p++;
                end
            end
        end

        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_pos", 32'(out_pos), 0);
        chk("rst_out_last", 32'(out_last), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 1);
        chk("post_rst_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        // all-100 block
        for (int i = 0; i < 64; i++) blk[i] = 100;
        fork
            begin
                send_block(d);
                in_valid = 1'b0;
                lat_check();
            end
            drain(64, 1'b0, f, l);
        join
        chk("t1_pos0", cap12[0], 100);
        chk("t1_pos1", cap12[1], 100);
        chk("t1_pos2", cap12[2], 100);
        chk("t1_pos3", cap12[3], 50);
        chk("t1_pos63", cap12[63], R63);

        // negative corner values
        fill_rand();
        blk[0] = -2048;
        blk[63] = -64;
        fork
            begin send_block(d); in_valid = 1'b0; end
            drain(64, 1'b0, f, l);
        join
        chk("t2_neg64", cap12[63], -R63);
        chk("t2_min12", cap12[0], -2048);
        chk("t2_min8", cap8[0], -128);

        fill_rand();
        blk[63] = -100;
        fork
            begin send_block(d); in_valid = 1'b0; end
            drain(64, 1'b0, f, l);
        join
        chk("t2_neg100", cap12[63], -R63);

        // QW=8 saturation
        fill_rand();
        blk[0] = 2047;
        blk[1] = 300;
        fork
            begin send_block(d); in_valid = 1'b0; end
            drain(64, 1'b0, f, l);
        join
        chk("t6_max8", cap8[0], 127);
        chk("t6_s0_8", cap8[1], 127);
        chk("t6_max12", cap12[0], 2047);
        chk("t6_s0_12", cap12[1], 300);

        // backpressure toggling
        fill_rand();
        fork
            begin send_block(d); in_valid = 1'b0; end
            drain(64, 1'b1, f, l);
        join
        chk("t3_sb_empty", sbq.size(), 0);

        // three blocks back to back
        p63_cyc = -100;
        d2 = -1;
        fork
            begin
                fill_rand();
                send_block(d);
                fill_rand();
                send_block(d);
                @(negedge clk);
                chk("t4_rdy_drop", 32'(in_ready), 0);
                @(posedge clk);
                #1;
                fill_rand();
                send_block(d2);
                in_valid = 1'b0;
            end
            drain(192, 1'b0, f, l);
        join
        chk("t4_rdy_return", d2, p63_cyc + 1);
        chk("t4_gapless", l - f, 191);
        chk("t4_sb_empty", sbq.size(), 0);

        // reset in the middle of a block
        fill_rand();
        for (int r = 0; r < 4; r++) send_row(r, d);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rdy_in_rst", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rdy_after", 32'(in_ready), 1);
        chk("t5_valid_after", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        fill_rand();
        fork
            begin
                send_block(d);
                in_valid = 1'b0;
                lat_check();
            end
            drain(64, 1'b0, f, l);
        join
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_idle", 32'(out_valid), 0);
        end
        chk("t5_sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
